// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input
// and the decode-side valid/ready handshake.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  imem_req_valid;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic [DATA_WIDTH-1:0] instr_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_pc,
    output instr_valid, instr, instr_pc, instr_pc_plus4,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_pc,
    input  instr_valid, instr, instr_pc, instr_pc_plus4,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited in-order requests,
// buffers responses in a small FIFO and flushes on branch/jump redirect.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] WORD = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] fetch_pc, expect_pc, redirect_tgt;
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pc_q   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, outstanding, discard, rsp_dec;
  logic [CW:0]           inflight;
  logic                  has_credit, fire, rsp_ok, push, pop, head_valid;

  // Credit > 0 expressed as count + outstanding < FIFO_DEPTH, avoiding underflow.
  assign inflight     = {1'b0, count} + {1'b0, outstanding};
  assign has_credit   = inflight < (CW+1)'(FIFO_DEPTH);
  assign redirect_tgt = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};

  assign bus.imem_req_valid = rst_n & ~bus.redirect & has_credit;
  assign bus.imem_req_addr  = fetch_pc;
  assign fire       = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_ok     = bus.imem_rsp_valid & (outstanding != '0);
  assign rsp_dec    = CW'(rsp_ok);
  assign push       = rsp_ok & (discard == '0);
  assign head_valid = count != '0;
  assign pop        = rst_n & head_valid & bus.instr_ready;

  // Head fields come straight from FIFO registers; zeroed while in reset.
  assign bus.instr_valid    = rst_n & head_valid;
  assign bus.instr          = rst_n ? data_q[rd_ptr] : '0;
  assign bus.instr_pc       = rst_n ? pc_q[rd_ptr] : '0;
  assign bus.instr_pc_plus4 = rst_n ? pc_q[rd_ptr] + WORD : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      expect_pc   <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (bus.redirect) begin
      // Every request still in flight predates the redirect, so all are stale.
      fetch_pc    <= redirect_tgt;
      expect_pc   <= redirect_tgt;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - rsp_dec;
      discard     <= outstanding - rsp_dec;
    end else begin
      if (fire) fetch_pc <= fetch_pc + WORD;
      outstanding <= outstanding + CW'(fire) - rsp_dec;
      if (rsp_ok && discard != '0) discard <= discard - CW'(1);
      if (push) begin
        expect_pc <= expect_pc + WORD;
        wr_ptr    <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !bus.redirect && push) begin
      data_q[wr_ptr] <= bus.imem_rsp_data;
      pc_q[wr_ptr]   <= expect_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for the back-pressure case plus
// hand-written sequences for latency, redirect, stall and wrap/reset corners.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;
  int   errs   = 0;
  int   checks = 0;

  fetch_unit_if #(.DATA_WIDTH(32)) b0 ();
  fetch_unit_if #(.DATA_WIDTH(32)) b1 ();

  fetch_unit #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  fetch_unit #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1));

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model for dut: in-order, fixed latency, stale responses still returned
  typedef struct { logic [31:0] a; int due; } pend_t;
  typedef struct { logic [31:0] pc, p4, ins; } pop_t;
  pend_t       mq[$];
  pop_t        pq[$], pq1[$];
  logic [31:0] fq[$], fq1[$];
  int          cyc = 0;
  int          lat = 1;

  always @(posedge clk) begin
    if (!rst_n) mq.delete();
    else begin
      if (b0.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (b0.imem_req_valid && b0.imem_req_ready) begin
        mq.push_back('{b0.imem_req_addr, cyc + 1 + lat});
        fq.push_back(b0.imem_req_addr);
      end
      if (b0.instr_valid && b0.instr_ready)
        pq.push_back('{b0.instr_pc, b0.instr_pc_plus4, b0.instr});
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc + 1) begin
      b0.imem_rsp_valid = 1'b1;
      b0.imem_rsp_data  = memf(mq[0].a);
    end else begin
      b0.imem_rsp_valid = 1'b0;
      b0.imem_rsp_data  = '0;
    end
  end

  // dut1: single-cycle memory, always ready
  logic        p1v = 1'b0;
  logic [31:0] p1a = '0;
  always @(posedge clk) begin
    p1v = rst1_n && b1.imem_req_valid && b1.imem_req_ready;
    p1a = b1.imem_req_addr;
    if (rst1_n && p1v) fq1.push_back(p1a);
    if (rst1_n && b1.instr_valid && b1.instr_ready)
      pq1.push_back('{b1.instr_pc, b1.instr_pc_plus4, b1.instr});
  end
  always @(negedge clk) begin
    b1.imem_rsp_valid = p1v;
    b1.imem_rsp_data  = memf(p1a);
  end

  task automatic do_reset(input logic ir, input logic mr);
    @(negedge clk);
    rst_n = 1'b0;
    b0.redirect = 1'b0;
    b0.redirect_pc = '0;
    b0.instr_ready = ir;
    b0.imem_req_ready = mr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", b0.imem_req_valid, 0);
    chk("rst_instr_valid", b0.instr_valid, 0);
    chk("rst_instr", b0.instr, 0);
    chk("rst_instr_pc", b0.instr_pc, 0);
    chk("rst_pc_plus4", b0.instr_pc_plus4, 0);
    fq.delete();
    pq.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_pop(input string name);
    for (int i = 0; i < 30 && pq.size() == 0; i++) @(negedge clk);
    chk({name, "_got_instr"}, pq.size() > 0, 1);
  endtask

  typedef struct {
    logic ir, mr, rv;
    logic [31:0] addr;
    logic iv;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    b0.redirect = 1'b0; b0.redirect_pc = '0;
    b0.imem_req_ready = 1'b1; b0.instr_ready = 1'b1;
    b1.redirect = 1'b0; b1.redirect_pc = '0;
    b1.imem_req_ready = 1'b1; b1.instr_ready = 1'b1;

    // Decode stalled, memory latency 1: four requests, then credit runs out
    tbl[0]  = '{0, 1, 1, 32'h00, 0, 32'h0};
    tbl[1]  = '{0, 1, 1, 32'h04, 0, 32'h0};
    tbl[2]  = '{0, 1, 1, 32'h08, 1, 32'h0};
    tbl[3]  = '{0, 1, 1, 32'h0C, 1, 32'h0};
    tbl[4]  = '{0, 1, 0, 32'h00, 1, 32'h0};
    tbl[5]  = '{0, 1, 0, 32'h00, 1, 32'h0};
    tbl[6]  = '{0, 1, 0, 32'h00, 1, 32'h0};
    tbl[7]  = '{1, 1, 0, 32'h00, 1, 32'h0};
    tbl[8]  = '{1, 1, 1, 32'h10, 1, 32'h4};
    tbl[9]  = '{1, 1, 1, 32'h14, 1, 32'h8};
    tbl[10] = '{1, 1, 1, 32'h18, 1, 32'hC};

    lat = 1;
    do_reset(0, 1);
    for (int i = 0; i < 11; i++) begin
      b0.instr_ready = tbl[i].ir;
      b0.imem_req_ready = tbl[i].mr;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), b0.imem_req_valid, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("tbl%0d_req_addr", i), b0.imem_req_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_instr_valid", i), b0.instr_valid, tbl[i].iv);
      if (tbl[i].iv) begin
        chk($sformatf("tbl%0d_instr_pc", i), b0.instr_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_pc_plus4", i), b0.instr_pc_plus4, tbl[i].pc + 32'd4);
        chk($sformatf("tbl%0d_instr", i), b0.instr, memf(tbl[i].pc));
      end
      @(negedge clk);
    end

    // Streaming: latency 1, decode always ready
    do_reset(1, 1);
    repeat (8) @(negedge clk);
    chk("stream_fire_count_ge4", fq.size() >= 4, 1);
    chk("stream_pop_count_ge3", pq.size() >= 3, 1);
    if (fq.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("stream_addr%0d", i), fq[i], 32'(4 * i));
    if (pq.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("stream_pc%0d", i), pq[i].pc, 32'(4 * i));
        chk($sformatf("stream_p4_%0d", i), pq[i].p4, 32'(4 * i + 4));
        chk($sformatf("stream_ins%0d", i), pq[i].ins, memf(32'(4 * i)));
      end

    // Redirect with two requests in flight at latency 3
    lat = 3;
    do_reset(1, 1);
    @(negedge clk);
    @(negedge clk);
    b0.imem_req_ready = 1'b0;
    b0.redirect = 1'b1;
    b0.redirect_pc = 32'h200;
    #1;
    chk("rdr_no_req_in_redirect", b0.imem_req_valid, 0);
    @(negedge clk);
    b0.redirect = 1'b0;
    b0.imem_req_ready = 1'b1;
    #1;
    chk("rdr_discard", 32'(dut.discard), 2);
    chk("rdr_req_addr", b0.imem_req_addr, 32'h200);
    wait_pop("rdr");
    if (pq.size() > 0) begin
      chk("rdr_pc", pq[0].pc, 32'h200);
      chk("rdr_p4", pq[0].p4, 32'h204);
      chk("rdr_ins", pq[0].ins, memf(32'h200));
    end

    // Redirect coinciding with a response and a pop, unaligned target
    lat = 2;
    do_reset(0, 1);
    repeat (3) @(negedge clk);
    b0.instr_ready = 1'b1;
    b0.redirect = 1'b1;
    b0.redirect_pc = 32'h103;
    #1;
    chk("rdr2_pop_pending", b0.instr_valid, 1);
    chk("rdr2_rsp_pending", b0.imem_rsp_valid, 1);
    @(negedge clk);
    b0.redirect = 1'b0;
    #1;
    chk("rdr2_fifo_empty", b0.instr_valid, 0);
    chk("rdr2_req_valid", b0.imem_req_valid, 1);
    chk("rdr2_req_addr", b0.imem_req_addr, 32'h100);
    chk("rdr2_discard", 32'(dut.discard), 1);
    chk("rdr2_outstanding", 32'(dut.outstanding), 1);
    pq.delete();
    wait_pop("rdr2");
    if (pq.size() > 0) begin
      chk("rdr2_pc", pq[0].pc, 32'h100);
      chk("rdr2_ins", pq[0].ins, memf(32'h100));
    end

    // Memory stalls for five cycles with a request pending
    lat = 1;
    do_reset(1, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d_valid", i), b0.imem_req_valid, 1);
      chk($sformatf("stall%0d_addr", i), b0.imem_req_addr, 32'h0);
      chk($sformatf("stall%0d_outstanding", i), 32'(dut.outstanding), 0);
      @(negedge clk);
    end
    b0.imem_req_ready = 1'b1;
    @(negedge clk);
    b0.imem_req_ready = 1'b0;
    #1;
    chk("stall_fires", fq.size(), 1);
    chk("stall_outstanding_after", 32'(dut.outstanding), 1);
    chk("stall_next_addr", b0.imem_req_addr, 32'h4);

    // Address wrap from RESET_PC near the top, then mid-stream reset
    @(negedge clk);
    rst_n = 1'b0;
    fq1.delete();
    pq1.delete();
    rst1_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("wrap_fire_count_ge3", fq1.size() >= 3, 1);
    chk("wrap_pop_count_ge2", pq1.size() >= 2, 1);
    if (fq1.size() >= 3) begin
      chk("wrap_addr0", fq1[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", fq1[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", fq1[2], 32'h0);
    end
    if (pq1.size() >= 2) begin
      chk("wrap_pc0", pq1[0].pc, 32'hFFFF_FFF8);
      chk("wrap_p4_0", pq1[0].p4, 32'hFFFF_FFFC);
      chk("wrap_pc1", pq1[1].pc, 32'hFFFF_FFFC);
      chk("wrap_p4_1", pq1[1].p4, 32'h0);
      chk("wrap_ins1", pq1[1].ins, memf(32'hFFFF_FFFC));
    end
    rst1_n = 1'b0;
    #1;
    chk("midrst_req_valid", b1.imem_req_valid, 0);
    chk("midrst_instr_valid", b1.instr_valid, 0);
    chk("midrst_instr", b1.instr, 0);
    chk("midrst_pc", b1.instr_pc, 0);
    chk("midrst_p4", b1.instr_pc_plus4, 0);
    @(negedge clk);
    fq1.delete();
    pq1.delete();
    rst1_n = 1'b1;
    #1;
    chk("midrst_fifo_empty", b1.instr_valid, 0);
    chk("midrst_restart_addr", b1.imem_req_addr, 32'hFFFF_FFF8);
    repeat (4) @(negedge clk);
    chk("midrst_pop_count_ge1", pq1.size() >= 1, 1);
    if (pq1.size() >= 1) chk("midrst_first_pc", pq1[0].pc, 32'hFFFF_FFF8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
